// File: rtl/pipeline_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_stall_ctrl
//
// Central stall/flush sequencer for a 5-stage RISC-V pipeline. It merges three
// hazard sources into the pipeline-register enables:
//   * load-use hazards between the ID and EX instructions,
//   * taken-branch flushes resolved in EX,
//   * multi-cycle data-memory wait states reported by MEM.
// The control outputs are combinational from the current state and the inputs,
// so a stall takes effect in the same cycle. The FSM state, the wait counter,
// the sticky timeout flag and the saturating performance counters are all
// registered.
//
// Ports
//   clk           in   1       rising-edge clock
//   rst           in   1       synchronous active-high reset
//   instr_id      in   32      ID instruction (rs1=[19:15], rs2=[24:20])
//   id_uses_rs2   in   1       ID instruction reads rs2
//   ex_rd         in   REG_AW  destination register of the EX instruction
//   ex_memread    in   1       EX instruction is a load
//   branch_taken  in   1       EX resolved a taken branch/jump
//   mem_req       in   1       MEM stage issues a data-memory access
//   mem_ready     in   1       data memory completes the access this cycle
//   pc_write      out  1       PC load enable
//   ifid_write    out  1       IF/ID load enable
//   ifid_flush    out  1       IF/ID cleared to NOP on the next edge
//   idex_bubble   out  1       ID/EX loads a NOP
//   exmem_hold    out  1       EX/MEM and MEM/WB hold their contents
//   mem_timeout   out  1       sticky: memory wait exceeded MAX_MEM_WAIT
//   stall_cycles  out  CNT_W   cycles with pc_write=0 (saturating)
//   flush_count   out  CNT_W   branch flushes issued (saturating)
// -----------------------------------------------------------------------------
module pipeline_stall_ctrl #(
  parameter int REG_AW       = 5,
  parameter int MAX_MEM_WAIT = 15,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr_id,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_memread,
  input  logic              branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              exmem_hold,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);

  // Wide enough to hold MAX_MEM_WAIT itself.
  localparam int WAIT_W = (MAX_MEM_WAIT < 1) ? 1 : $clog2(MAX_MEM_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_MEM_WAIT);
  localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic              mem_timeout_reg, mem_timeout_next;
  logic [CNT_W-1:0]  stall_cycles_reg, stall_cycles_next;
  logic [CNT_W-1:0]  flush_count_reg, flush_count_next;

  // ---------------------------------------------------------------------------
  // Hazard decode
  // ---------------------------------------------------------------------------
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              load_use;
  logic              mem_miss;

  assign id_rs1 = instr_id[15 +: REG_AW];
  assign id_rs2 = instr_id[20 +: REG_AW];

  // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
  assign load_use = ex_memread && (ex_rd != '0) &&
                    ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

  assign mem_miss = mem_req && !mem_ready;

  // ---------------------------------------------------------------------------
  // Freeze decision: the whole pipeline stops while memory is outstanding.
  // In MEM_WAIT the EX inputs are frozen, so any branch_taken seen there is
  // simply the same branch waiting to be acted on at the release cycle.
  // ---------------------------------------------------------------------------
  logic freeze;

  always_comb begin
    freeze = 1'b0;
    case (state_reg)
      ST_RUN:      freeze = mem_miss;
      ST_MEM_WAIT: freeze = !mem_ready;
      ST_ERROR:    freeze = 1'b1;
      default:     freeze = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic (also wait counter and timeout flag)
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next       = state_reg;
    wait_cnt_next    = wait_cnt_reg;
    mem_timeout_next = mem_timeout_reg;
    case (state_reg)
      ST_RUN: begin
        if (mem_miss) begin
          // The first stalled cycle counts as wait cycle number one.
          state_next    = ST_MEM_WAIT;
          wait_cnt_next = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          state_next    = ST_RUN;
          wait_cnt_next = '0;
        end else if (wait_cnt_reg < WAIT_LIMIT) begin
          wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
        end else begin
          state_next       = ST_ERROR;
          mem_timeout_next = 1'b1;
        end
      end
      ST_ERROR: begin
        // Only reset leaves this state.
        state_next = ST_ERROR;
      end
      default: begin
        state_next    = ST_RUN;
        wait_cnt_next = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic
  // ---------------------------------------------------------------------------
  logic branch_flush;

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_hold   = 1'b0;
    branch_flush = 1'b0;
    if (rst) begin
      // Hold fetch and fill the front of the pipe with NOPs.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (freeze) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      exmem_hold = 1'b1;
    end else if (branch_taken) begin
      // The ID instruction is wrong-path, so a coincident load-use is moot.
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      branch_flush = 1'b1;
    end else if (load_use) begin
      // One cycle is enough: the load moves on to MEM at the next edge.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Performance counters (saturating, never wrap)
  // ---------------------------------------------------------------------------
  always_comb begin
    stall_cycles_next = stall_cycles_reg;
    flush_count_next  = flush_count_reg;
    if (!pc_write && (stall_cycles_reg != CNT_MAX)) begin
      stall_cycles_next = stall_cycles_reg + CNT_W'(1);
    end
    if (branch_flush && (flush_count_reg != CNT_MAX)) begin
      flush_count_next = flush_count_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_reg     <= '0;
      mem_timeout_reg  <= 1'b0;
      stall_cycles_reg <= '0;
      flush_count_reg  <= '0;
    end else begin
      wait_cnt_reg     <= wait_cnt_next;
      mem_timeout_reg  <= mem_timeout_next;
      stall_cycles_reg <= stall_cycles_next;
      flush_count_reg  <= flush_count_next;
    end
  end

  assign mem_timeout  = mem_timeout_reg;
  assign stall_cycles = stall_cycles_reg;
  assign flush_count  = flush_count_reg;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_stall_ctrl
//
// Directed scenarios followed by a randomized run, all compared every cycle
// against a behavioural model of the stall/flush rules. The counter width is
// reduced so that saturation is reachable in a short run.
// -----------------------------------------------------------------------------
module tb_pipeline_stall_ctrl;

  localparam int REG_AW  = 5;
  localparam int MAXW    = 15;
  localparam int CNT_W   = 6;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst;
  logic [31:0]       instr_id;
  logic              id_uses_rs2;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_memread;
  logic              branch_taken;
  logic              mem_req;
  logic              mem_ready;
  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic              idex_bubble;
  logic              exmem_hold;
  logic              mem_timeout;
  logic [CNT_W-1:0]  stall_cycles;
  logic [CNT_W-1:0]  flush_count;

  pipeline_stall_ctrl #(
    .REG_AW      (REG_AW),
    .MAX_MEM_WAIT(MAXW),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_id    (instr_id),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_memread  (ex_memread),
    .branch_taken(branch_taken),
    .mem_req     (mem_req),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .ifid_write  (ifid_write),
    .ifid_flush  (ifid_flush),
    .idex_bubble (idex_bubble),
    .exmem_hold  (exmem_hold),
    .mem_timeout (mem_timeout),
    .stall_cycles(stall_cycles),
    .flush_count (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Model: "in_wait" = a memory access is outstanding, "waited" = how many
  // consecutive cycles it has been outstanding, "dead" = timed out.
  bit m_in_wait;
  bit m_dead;
  int m_waited;
  int m_stall;
  int m_flush;
  bit m_to;

  function automatic logic [31:0] mk_instr(input int rs1, input int rs2);
    logic [31:0] v;
    v = 32'h0000_0033;
    v[19:15] = 5'(rs1);
    v[24:20] = 5'(rs2);
    v[11:7]  = 5'd1;
    return v;
  endfunction

  task automatic chk(input string tag, input string what,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  task automatic drive(input bit r, input logic [31:0] ins, input bit u2,
                       input int rd, input bit mr, input bit br,
                       input bit rq, input bit rdy);
    rst          = r;
    instr_id     = ins;
    id_uses_rs2  = u2;
    ex_rd        = REG_AW'(rd);
    ex_memread   = mr;
    branch_taken = br;
    mem_req      = rq;
    mem_ready    = rdy;
  endtask

  // One clock cycle: check outputs mid-cycle against the model, then advance it.
  task automatic step(input string tag);
    bit lu, frz;
    bit e_pc, e_ifw, e_fl, e_bub, e_hold;
    int rs1, rs2;
    @(negedge clk);
    rs1 = int'(instr_id[19:15]);
    rs2 = int'(instr_id[24:20]);
    lu  = ex_memread && (int'(ex_rd) != 0) &&
          ((int'(ex_rd) == rs1) || (id_uses_rs2 && (int'(ex_rd) == rs2)));
    frz = m_dead || (m_in_wait && !mem_ready) ||
          (!m_in_wait && mem_req && !mem_ready);
    if (rst)               {e_pc, e_ifw, e_fl, e_bub, e_hold} = 5'b00110;
    else if (frz)          {e_pc, e_ifw, e_fl, e_bub, e_hold} = 5'b00001;
    else if (branch_taken) {e_pc, e_ifw, e_fl, e_bub, e_hold} = 5'b11110;
    else if (lu)           {e_pc, e_ifw, e_fl, e_bub, e_hold} = 5'b00010;
    else                   {e_pc, e_ifw, e_fl, e_bub, e_hold} = 5'b11000;
    chk(tag, "pc_write",     32'(pc_write),     32'(e_pc));
    chk(tag, "ifid_write",   32'(ifid_write),   32'(e_ifw));
    chk(tag, "ifid_flush",   32'(ifid_flush),   32'(e_fl));
    chk(tag, "idex_bubble",  32'(idex_bubble),  32'(e_bub));
    chk(tag, "exmem_hold",   32'(exmem_hold),   32'(e_hold));
    chk(tag, "mem_timeout",  32'(mem_timeout),  32'(m_to));
    chk(tag, "stall_cycles", 32'(stall_cycles), 32'(m_stall));
    chk(tag, "flush_count",  32'(flush_count),  32'(m_flush));
    @(posedge clk);
    if (rst) begin
      m_in_wait = 0; m_dead = 0; m_waited = 0;
      m_stall = 0; m_flush = 0; m_to = 0;
    end else begin
      if (!e_pc && m_stall < CNT_MAX) m_stall++;
      if (!frz && branch_taken && m_flush < CNT_MAX) m_flush++;
      if (!m_dead) begin
        if (!m_in_wait) begin
          if (mem_req && !mem_ready) begin
            m_in_wait = 1;
            m_waited  = 1;
          end
        end else if (mem_ready) begin
          m_in_wait = 0;
          m_waited  = 0;
        end else if (m_waited < MAXW) begin
          m_waited++;
        end else begin
          m_dead = 1;
          m_to   = 1;
        end
      end
    end
    #1;
  endtask

  initial begin
    logic [31:0] add_x10;
    logic [31:0] rs2_only;
    add_x10  = 32'h00A5_0533;      // add x10, x10, x10
    rs2_only = mk_instr(5, 10);    // rs1=x5, rs2=x10
    m_in_wait = 0; m_dead = 0; m_waited = 0;
    m_stall = 0; m_flush = 0; m_to = 0;
    drive(1, 32'h13, 0, 0, 0, 0, 0, 1);

    // Reset behaviour
    step("reset0");
    step("reset1");
    drive(0, 32'h13, 0, 0, 0, 0, 0, 1);
    step("idle");

    // 1. load-use on rs1: one stall cycle
    drive(0, add_x10, 0, 10, 1, 0, 0, 1);
    step("lu_rs1");
    drive(0, add_x10, 0, 3, 0, 0, 0, 1);
    step("lu_after");
    chk("lu_rs1", "stall_total", 32'(stall_cycles), 32'd1);

    // 2. no-stall cases
    drive(0, add_x10, 1, 0, 1, 0, 0, 1);
    step("lu_rd0");
    drive(0, add_x10, 1, 10, 0, 0, 0, 1);
    step("lu_noload");
    drive(0, rs2_only, 0, 10, 1, 0, 0, 1);
    step("lu_rs2_unused");
    drive(0, rs2_only, 1, 10, 1, 0, 0, 1);
    step("lu_rs2_used");

    // 3. branch overrides load-use
    drive(0, add_x10, 0, 10, 1, 1, 0, 1);
    step("br_lu");
    drive(0, 32'h13, 0, 0, 0, 0, 0, 1);
    step("br_after");
    chk("br_lu", "flush_total", 32'(flush_count), 32'd1);

    // 4. three-cycle memory wait; branch seen during the wait flushes on release
    drive(0, 32'h13, 0, 0, 0, 0, 1, 0);
    step("mw_c1");
    drive(0, 32'h13, 0, 0, 0, 1, 1, 0);
    step("mw_c2");
    step("mw_c3");
    drive(0, 32'h13, 0, 0, 0, 1, 1, 1);
    step("mw_release");
    drive(0, 32'h13, 0, 0, 0, 0, 0, 1);
    step("mw_after");
    chk("mw", "flush_total", 32'(flush_count), 32'd2);

    // 5. timeout after MAXW+1 not-ready cycles, then stuck; counter saturates
    drive(0, 32'h13, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i <= MAXW; i++) step("to_wait");
    chk("to", "mem_timeout", 32'(mem_timeout), 32'd1);
    drive(0, 32'h13, 0, 0, 0, 1, 1, 1);
    for (int i = 0; i < 4; i++) step("to_stuck");
    drive(0, 32'h13, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < CNT_MAX; i++) step("sat");
    chk("sat", "stall_max", 32'(stall_cycles), 32'(CNT_MAX));
    drive(1, 32'h13, 0, 0, 0, 0, 0, 1);
    step("to_reset");
    drive(0, 32'h13, 0, 0, 0, 0, 0, 1);
    step("to_cleared");
    chk("to_cleared", "stall_zero", 32'(stall_cycles), 32'd0);

    // 6. reset in the middle of a memory wait
    drive(0, 32'h13, 0, 0, 0, 0, 1, 0);
    step("mid_c1");
    step("mid_c2");
    drive(1, 32'h13, 0, 0, 0, 0, 1, 0);
    step("mid_rst");
    drive(0, 32'h13, 0, 0, 0, 0, 0, 1);
    step("mid_after");

    // Randomized run
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 59) == 0),
            mk_instr($urandom_range(0, 3), $urandom_range(0, 3)),
            $urandom_range(0, 1),
            $urandom_range(0, 3),
            $urandom_range(0, 1),
            ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) != 0));
      step("rand");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
